// File: rtl/sprite_arb_pkg.sv
// Shared constants and types for the sprite frame RAM and its read arbiter.
package sprite_arb_pkg;
  localparam int SPRITE_W        = 50;
  localparam int SPRITE_DEPTH    = SPRITE_W * SPRITE_W;
  localparam int SPRITE_ADDR_W   = 19;
  localparam int SPRITE_DATA_W   = 5;
  localparam int TRANSPARENT_IDX = 0;

  typedef logic [SPRITE_ADDR_W-1:0] sprite_addr_t;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: scans i_req starting at i_ptr, wraps
// modulo N and returns the first asserted index as one-hot plus binary.
// Shared by the tank and bullet arbiters.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_vld
);

  logic [IW:0] w_j;

  // Priority scan from the pointer position, first hit wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    w_j   = '0;
    for (int k = 0; k < N; k++) begin
      w_j = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_j >= (IW+1)'(N)) w_j = w_j - (IW+1)'(N);
      if (!o_vld && i_req[w_j[IW-1:0]]) begin
        o_vld                = 1'b1;
        o_gnt[w_j[IW-1:0]]   = 1'b1;
        o_idx                = w_j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Sprite frame RAM port sharer: loader writes take absolute priority, reads
// from the draw engines are granted round-robin and returned one cycle later
// tagged with the requester id.
// Optional address bounds checking is enabled with SPRITE_ARB_BOUNDS_EN.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = SPRITE_ADDR_W,
  parameter int DATA_W = SPRITE_DATA_W,
  parameter int DEPTH  = SPRITE_DEPTH
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          gnt,
  output logic                      rsp_valid,
  output logic [$clog2(N_REQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
`ifdef SPRITE_ARB_BOUNDS_EN
  output logic                      rsp_err,
`endif
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_write_address,
  output logic [DATA_W-1:0]         ram_data_In,
  output logic [ADDR_W-1:0]         ram_read_address,
  input  logic [DATA_W-1:0]         ram_data_Out
);

  localparam int IDW = $clog2(N_REQ);

  logic [IDW-1:0]    r_ptr;
  logic              r_vld_p1;
  logic [IDW-1:0]    r_id_p1;
  logic [ADDR_W-1:0] r_last_addr;

  logic [N_REQ-1:0]  w_req_eff;
  logic [N_REQ-1:0]  w_pick_gnt;
  logic [IDW-1:0]    w_pick_idx;
  logic              w_pick_vld;
  logic [ADDR_W-1:0] w_addr_arr [N_REQ];
  logic [ADDR_W-1:0] w_gaddr;
  logic              w_rd_oob;
  logic              w_rd_issue;

  // A loader write blocks every read in the same cycle.
  assign w_req_eff = wr_en ? '0 : req;

  rr_picker #(.N(N_REQ), .IW(IDW)) u_pick (
    .i_req (w_req_eff),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_vld (w_pick_vld)
  );

  // Unpack the per-requester address slices.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) w_addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
  end

  assign gnt               = w_pick_gnt;
  assign w_gaddr           = w_addr_arr[w_pick_idx];
  assign ram_write_address = wr_addr;
  assign ram_data_In       = wr_data;

`ifdef SPRITE_ARB_BOUNDS_EN
  assign w_rd_oob = (w_gaddr >= ADDR_W'(DEPTH));
  assign ram_we   = wr_en && (wr_addr < ADDR_W'(DEPTH));
`else
  assign w_rd_oob = 1'b0;
  assign ram_we   = wr_en;
`endif

  // Only in-range grants move the RAM address; otherwise it stays put.
  assign w_rd_issue       = w_pick_vld && !w_rd_oob;
  assign ram_read_address = w_rd_issue ? w_gaddr : r_last_addr;

  // Remember the last issued read address (datapath, no reset needed).
  always_ff @(posedge Clk) begin
    if (w_rd_issue) r_last_addr <= w_gaddr;
  end

  // ---- stage p0 -> p1: grant becomes response one cycle later ----
  // Round-robin pointer and response tag pipeline.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ptr    <= '0;
      r_vld_p1 <= 1'b0;
      r_id_p1  <= '0;
    end else begin
      r_vld_p1 <= w_pick_vld;
      if (w_pick_vld) begin
        r_id_p1 <= w_pick_idx;
        r_ptr   <= (w_pick_idx == IDW'(N_REQ-1)) ? '0 : w_pick_idx + 1'b1;
      end
    end
  end

  assign rsp_valid = r_vld_p1;
  assign rsp_id    = r_id_p1;

`ifdef SPRITE_ARB_BOUNDS_EN
  logic r_err_p1;

  // Flag an out-of-range grant so its response returns a transparent pixel.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_err_p1 <= 1'b0;
    else          r_err_p1 <= w_pick_vld && w_rd_oob;
  end

  assign rsp_err  = r_err_p1;
  assign rsp_data = r_err_p1 ? DATA_W'(TRANSPARENT_IDX) : ram_data_Out;
`else
  assign rsp_data = ram_data_Out;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a 1-cycle registered RAM model.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_sprite_rom_arbiter;
  localparam int N  = 4;
  localparam int AW = 19;
  localparam int DW = 5;

  logic            Clk;
  logic            Reset_n;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_data;
`ifdef SPRITE_ARB_BOUNDS_EN
  logic            rsp_err;
`endif
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            ram_we;
  logic [AW-1:0]   ram_write_address;
  logic [DW-1:0]   ram_data_In;
  logic [AW-1:0]   ram_read_address;
  logic [DW-1:0]   ram_data_Out;

  logic [DW-1:0]   mem [0:2499];

  int n_total = 0;
  int n_bad   = 0;

  sprite_rom_arbiter dut (
    .Clk               (Clk),
    .Reset_n           (Reset_n),
    .req               (req),
    .req_addr          (req_addr),
    .gnt               (gnt),
    .rsp_valid         (rsp_valid),
    .rsp_id            (rsp_id),
    .rsp_data          (rsp_data),
`ifdef SPRITE_ARB_BOUNDS_EN
    .rsp_err           (rsp_err),
`endif
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .ram_we            (ram_we),
    .ram_write_address (ram_write_address),
    .ram_data_In       (ram_data_In),
    .ram_read_address  (ram_read_address),
    .ram_data_Out      (ram_data_Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Sprite RAM model: synchronous write, registered read.
  always @(posedge Clk) begin
    if (ram_we && ram_write_address < 2500) mem[ram_write_address] <= ram_data_In;
    if (ram_read_address < 2500) ram_data_Out <= mem[ram_read_address];
    else                         ram_data_Out <= '0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_addr(input int i, input int a);
    req_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic rsp_chk(input string tag, input int vld, input int id, input int data);
    chk({tag, "_vld"}, 32'(rsp_valid), 32'(vld));
    if (vld != 0) begin
      chk({tag, "_id"},   32'(rsp_id),   32'(id));
      chk({tag, "_data"}, 32'(rsp_data), 32'(data));
    end
  endtask

  int exp_g [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < 2500; i++) mem[i] = DW'(i % 16);
    mem[17] = 5'h3;
    Reset_n = 1'b0; req = '0; req_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) step();
    #1;
    chk("rst_vld", 32'(rsp_valid), 0);
    chk("rst_id",  32'(rsp_id),    0);
    chk("rst_gnt", 32'(gnt),       0);
`ifdef SPRITE_ARB_BOUNDS_EN
    chk("rst_err", 32'(rsp_err),   0);
`endif
    Reset_n = 1'b1;

    // Single request from requester 0, word 17 holds 0x3.
    step(); req = 4'b0001; set_addr(0, 17); #1;
    chk("single_gnt",  32'(gnt), 32'b0001);
    chk("single_addr", 32'(ram_read_address), 17);
    step(); req = '0; #1;
    rsp_chk("single_rsp", 1, 0, 3);
    chk("idle_gnt", 32'(gnt), 0);
    step(); #1;
    chk("idle_vld",  32'(rsp_valid), 0);
    chk("idle_hold", 32'(ram_read_address), 17);

    // All requesting for 8 cycles, pointer starts at 1.
    for (int i = 0; i < N; i++) set_addr(i, 100 + i);
    for (int k = 0; k < 8; k++) begin
      step(); req = 4'b1111; #1;
      chk($sformatf("rr_gnt%0d", k),  32'(gnt), 32'(1 << exp_g[k]));
      chk($sformatf("rr_addr%0d", k), 32'(ram_read_address), 32'(100 + exp_g[k]));
      if (k == 0) rsp_chk("rr_rsp0", 0, 0, 0);
      else        rsp_chk($sformatf("rr_rsp%0d", k), 1, exp_g[k-1], 4 + exp_g[k-1]);
    end
    step(); req = '0; #1;
    rsp_chk("rr_rsp8", 1, 0, 4);
    chk("rr_hold", 32'(ram_read_address), 100);

    // Write collides with req=1010 at pointer 1: write wins, pointer holds.
    step(); req = 4'b1010; set_addr(1, 42); set_addr(3, 200);
    wr_en = 1'b1; wr_addr = 42; wr_data = 5'h7; #1;
    chk("wr_gnt",  32'(gnt), 0);
    chk("wr_we",   32'(ram_we), 1);
    chk("wr_wa",   32'(ram_write_address), 42);
    chk("wr_wd",   32'(ram_data_In), 7);
    chk("wr_vld",  32'(rsp_valid), 0);
    step(); wr_en = 1'b0; #1;
    chk("wr_resume_gnt", 32'(gnt), 32'b0010);
    chk("wr_resume_we",  32'(ram_we), 0);
    chk("wr_resume_ra",  32'(ram_read_address), 42);
    chk("wr_resume_vld", 32'(rsp_valid), 0);
    step(); req = 4'b1000; #1;
    chk("wr_next_gnt", 32'(gnt), 32'b1000);
    rsp_chk("wr_readback", 1, 1, 7);
    step(); req = '0; #1;
    rsp_chk("wr_r3", 1, 3, 8);

    // Sparse requests with wrap-around; boundary address 2499.
    step(); req = 4'b0010; #1;
    chk("sp_gnt1", 32'(gnt), 32'b0010);
    step(); req = 4'b1000; #1;
    chk("sp_gnt3", 32'(gnt), 32'b1000);
    rsp_chk("sp_rsp1", 1, 1, 7);
    step(); req = 4'b0001; set_addr(0, 2499); #1;
    chk("sp_gnt0", 32'(gnt), 32'b0001);
    chk("sp_ra",   32'(ram_read_address), 2499);
    rsp_chk("sp_rsp3", 1, 3, 8);
    step(); req = '0; #1;
    rsp_chk("edge_2499", 1, 0, 3);

`ifdef SPRITE_ARB_BOUNDS_EN
    // Out-of-range read and write.
    step(); req = 4'b0001; set_addr(0, 2500); #1;
    chk("oob_gnt",  32'(gnt), 32'b0001);
    chk("oob_ra",   32'(ram_read_address), 2499);
    step(); req = '0; wr_en = 1'b1; wr_addr = 3000; wr_data = 5'h9; #1;
    rsp_chk("oob_rsp", 1, 0, 0);
    chk("oob_err",  32'(rsp_err), 1);
    chk("oob_we",   32'(ram_we), 0);
    step(); wr_en = 1'b0; #1;
    chk("oob_err_clr", 32'(rsp_err), 0);
    chk("oob_vld_clr", 32'(rsp_valid), 0);
`endif

    // Reset in the cycle after a grant discards the response.
    step(); req = 4'b0100; set_addr(2, 300); #1;
    chk("rst_pre_gnt", 32'(gnt), 32'b0100);
    step(); req = '0; Reset_n = 1'b0; #1;
    chk("rst_kill_vld", 32'(rsp_valid), 0);
    chk("rst_kill_id",  32'(rsp_id), 0);
    step(); Reset_n = 1'b1; #1;
    chk("rst_post_vld", 32'(rsp_valid), 0);
    step(); req = 4'b1111; for (int i = 0; i < N; i++) set_addr(i, 100 + i); #1;
    chk("rst_ptr_gnt", 32'(gnt), 32'b0001);
    chk("rst_no_stale", 32'(rsp_valid), 0);
    step(); req = '0; #1;
    rsp_chk("rst_after", 1, 0, 4);

    step();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares the single read/write port of one sprite frame RAM (50x50 sprite, 2500 words, 4-bit palette index on a 5-bit data bus) among N_REQ pixel-fetch requesters (tank and bullet draw engines).
- Round-robin arbitration of reads; the loader write port has absolute priority.
- Tracks the RAM's 1-cycle registered read latency and returns data tagged with the requester id.
- Sits between the draw engines and the sprite RAM instance in the video path.

Parameters:
- N_REQ, 4, number of read requesters (2..8)
- ADDR_W, 19, address width of the RAM ports
- DATA_W, 5, data width of the RAM ports
- DEPTH, 2500, number of valid RAM words

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester read request; held until granted
- req_addr  in  N_REQ*ADDR_W  packed per-requester read address; requester i uses slice i
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as the accepted request
- rsp_valid  out  1  read data valid
- rsp_id  out  $clog2(N_REQ)  requester that owns rsp_data
- rsp_data  out  DATA_W  returned pixel data
- wr_en  in  1  loader write strobe
- wr_addr  in  ADDR_W  loader write address
- wr_data  in  DATA_W  loader write data
- ram_we  out  1  to RAM we
- ram_write_address  out  ADDR_W  to RAM write_address
- ram_data_In  out  DATA_W  to RAM data_In
- ram_read_address  out  ADDR_W  to RAM read_address
- ram_data_Out  in  DATA_W  from RAM data_Out

Behaviour:
- Reset (Reset_n low, async): rr_ptr=0, rsp_valid=0, rsp_id=0. Any in-flight read is discarded and no response is issued after reset release. Because gnt is combinational, it is 0 whenever req=0 or wr_en=1.
- Write path:
  - ram_we=wr_en, ram_write_address=wr_addr, ram_data_In=wr_data, all combinational.
  - When wr_en=1: gnt=0, rr_ptr unchanged, no read issued that cycle.
- Arbitration (wr_en=0):
  - Scan req starting at index rr_ptr and wrapping modulo N_REQ; grant the first asserted index g.
  - gnt[g]=1; ram_read_address=req_addr slice g. Exactly one grant per cycle at most.
  - On a grant, rr_ptr <= (g+1) mod N_REQ, wrapping N_REQ-1 -> 0. With no grant, rr_ptr holds.
- Idle read address: when nothing is granted, ram_read_address holds the last granted address. This avoids needless RAM address toggling.
- Response:
  - Grant in cycle t -> rsp_valid=1 and rsp_id=g in cycle t+1.
  - rsp_data=ram_data_Out, combinational pass-through of the RAM's registered output.
  - Latency is exactly 1 cycle. Throughput is 1 read per cycle.
- rsp_valid is 0 in every cycle not preceded by a grant.
- A requester deasserting req without a grant is legal; no response is generated.
- Fairness: with all N_REQ requesting continuously, each is granted once every N_REQ cycles.
- Simultaneous wr_en and req: the write wins. Pending requesters stall, and the grant order resumes from the unchanged rr_ptr.

Optional Feature:
- SPRITE_ARB_BOUNDS_EN defined:
  - A granted address >= DEPTH is still granted and still advances rr_ptr, but ram_read_address holds its previous value.
  - The cycle after such a grant: rsp_valid=1, rsp_data=0 (transparent palette index), and output rsp_err=1. rsp_err is 0 otherwise and 0 at reset.
  - A write with wr_addr >= DEPTH is suppressed (ram_we=0).
- SPRITE_ARB_BOUNDS_EN undefined: no rsp_err port; addresses pass unchecked.

Decomposition:
- Package sprite_arb_pkg: SPRITE_DEPTH=2500, SPRITE_W=50, SPRITE_ADDR_W=19, SPRITE_DATA_W=5, TRANSPARENT_IDX=0, and typedef sprite_addr_t.
- Sub-module rr_picker: combinational round-robin pick of a one-hot grant from a req vector and a pointer. It is reusable by the bullet arbiter.
- The top level holds rr_ptr, the response pipeline register and the write mux.

Test Plan:
- Single request: req=0001, req_addr[0]=17, RAM word 17=0x3 -> gnt=0001 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=0x3.
- All requesting for 8 cycles (N_REQ=4, reset rr_ptr=0) -> grants 0,1,2,3,0,1,2,3; responses follow 1 cycle later with matching ids.
- wr_en=1 with req=1010 and rr_ptr=1: write 0x7 to address 42 -> gnt=0000, rr_ptr stays 1. Next cycle wr_en=0 -> gnt=0010. Later read of 42 returns 0x7.
- Reset_n pulsed low in the cycle after a grant -> rsp_valid=0 immediately, rr_ptr=0; no stale response after release.
- Boundary address 2499 reads correctly. With SPRITE_ARB_BOUNDS_EN, address 2500 -> rsp_valid=1, rsp_data=0, rsp_err=1, RAM address unchanged.
- Sparse requests req=1000 then req=0001 with rr_ptr=2 -> grant 3 then 0, wrap-around verified.
